// File: rtl/kyber_bits_pkg.sv
// Shared types and constants for the Kyber bit/byte packing stages.
package kyber_bits_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } b2b_state_t;

  localparam int KYBER_MSG_BITS = 256;
  localparam int KYBER_N        = 256;

  // Bit offset of byte lane idx inside a flat bit vector.
  function automatic int unsigned byte_lane(input int unsigned idx);
    return idx * 8;
  endfunction

endpackage

// File: rtl/bytes_to_bits_stream.sv
// Assembles BYTE_LENGTH streamed bytes into one BIT_LENGTH-bit vector (valid/ready both sides).
// Optional synchronous clear input soft_clr enabled by defining BYTES_TO_BITS_SOFT_CLR_EN.
module bytes_to_bits_stream
  import kyber_bits_pkg::*;
#(
  parameter int BIT_LENGTH  = 2048,
  parameter int BYTE_LENGTH = BIT_LENGTH / 8,
  parameter int CNT_W       = $clog2(BYTE_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
  input  logic                  soft_clr,
`endif
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIT_LENGTH-1:0] bit_array,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      fill_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTE_LENGTH - 1);

  b2b_state_t            state_q, state_d;
  logic [CNT_W-1:0]      fill_count_q, fill_count_d;
  logic [BIT_LENGTH-1:0] bit_array_q, bit_array_d;
  logic                  in_ready_q, out_valid_q;
  logic                  clr;
  logic                  byte_xfer, out_xfer;

`ifdef BYTES_TO_BITS_SOFT_CLR_EN
  assign clr = soft_clr;
`else
  assign clr = 1'b0;
`endif

  // A clear cycle must not advertise readiness, since the byte would be dropped.
  assign in_ready  = in_ready_q & ~clr;
  assign out_valid = out_valid_q;
  assign bit_array = bit_array_q;
  assign fill_count = fill_count_q;

  assign byte_xfer = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    state_d      = state_q;
    fill_count_d = fill_count_q;
    bit_array_d  = bit_array_q;

    if (clr) begin
      state_d      = IDLE;
      fill_count_d = '0;
      bit_array_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, FILL: begin
          // fill_count is always 0 in IDLE, so both states write lane fill_count.
          if (byte_xfer) begin
            for (int unsigned k = 0; k < BYTE_LENGTH; k++) begin
              if (fill_count_q == CNT_W'(k)) begin
                bit_array_d[byte_lane(k) +: 8] = in_byte;
              end
            end
            fill_count_d = fill_count_q + CNT_W'(1);
            state_d      = (fill_count_q == LAST_IDX) ? DONE : FILL;
          end
        end
        DONE: begin
          if (out_xfer) begin
            state_d      = IDLE;
            fill_count_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the wide data register is reset too, so bit_array reads as zero before the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_count_q <= '0;
      bit_array_q  <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      bit_array_q  <= bit_array_d;
      in_ready_q   <= (state_d != DONE);
      out_valid_q  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
// Self-checking bench for bytes_to_bits_stream: directed steps plus random traffic against a byte-array model.
module tb_bytes_to_bits_stream;

  localparam int BL = 2048;
  localparam int NB = BL / 8;
  localparam int CW = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] bit_array;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fill_count;
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
  logic          soft_clr;
`endif

  logic [7:0]    s_in_byte;
  logic          s_in_valid;
  logic          s_in_ready;
  logic [15:0]   s_bit_array;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [1:0]    s_fill_count;

  always #5 clk = ~clk;

  bytes_to_bits_stream #(.BIT_LENGTH(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
    .soft_clr   (soft_clr),
`endif
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bit_array  (bit_array),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_count (fill_count)
  );

  bytes_to_bits_stream #(.BIT_LENGTH(16)) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
    .soft_clr   (1'b0),
`endif
    .in_byte    (s_in_byte),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .bit_array  (s_bit_array),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .fill_count (s_fill_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the frame as an array of bytes, plus a count and a "frame complete" flag.
  logic [7:0] m_bytes [NB];
  int         m_cnt;
  bit         m_done;

  function automatic logic [BL-1:0] model_vec();
    logic [BL-1:0] v;
    for (int k = 0; k < NB; k++) v[k*8 +: 8] = m_bytes[k];
    return v;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_done = 1'b0;
    for (int k = 0; k < NB; k++) m_bytes[k] = 8'h00;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
    if (soft_clr) begin
      model_reset();
      return;
    end
`endif
    if (!m_done && in_valid) begin
      m_bytes[m_cnt] = in_byte;
      m_cnt++;
      if (m_cnt == NB) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_cnt  = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [BL-1:0] exp);
    int bad;
    tests++;
    assert (bit_array === exp) else begin
      fails++;
      bad = 0;
      for (int k = NB - 1; k >= 0; k--) if (bit_array[k*8 +: 8] !== exp[k*8 +: 8]) bad = k;
      $error("FAIL %s: byte %0d observed %02h expected %02h", tag, bad,
             bit_array[bad*8 +: 8], exp[bad*8 +: 8]);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'(!m_done));
    check({tag, "_out_valid"}, 32'(out_valid),  32'(m_done));
    check({tag, "_fill"},      32'(fill_count), m_cnt);
    check_vec({tag, "_vec"}, model_vec());
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_byte     = 8'h00;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    s_in_byte   = 8'h00;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
`ifdef BYTES_TO_BITS_SOFT_CLR_EN
    soft_clr    = 1'b0;
`endif
    model_reset();

    // Reset values.
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Bit ordering on a 16-bit instance.
    s_in_valid = 1'b1;
    s_in_byte  = 8'hA5;
    @(posedge clk); #1;
    s_in_byte  = 8'h3C;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("small_out_valid", 32'(s_out_valid), 32'd1);
    check("small_vec", 32'(s_bit_array), 32'h3CA5);
    check("small_bit0", 32'(s_bit_array[0]), 32'd1);
    check("small_bit8", 32'(s_bit_array[8]), 32'd0);
    check("small_in_ready", 32'(s_in_ready), 32'd0);
    check("small_fill", 32'(s_fill_count), 32'd2);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("small_accept", 32'(s_out_valid), 32'd0);

    // Sequential fill 0x00..0xFF, no backpressure.
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(i);
      step("seq");
    end
    check("seq_b0",   32'(bit_array[7:0]),       32'h00);
    check("seq_b1",   32'(bit_array[15:8]),      32'h01);
    check("seq_b255", 32'(bit_array[2047:2040]), 32'hFF);
    check("seq_fill", 32'(fill_count),           32'd256);
    check("seq_ovld", 32'(out_valid),            32'd1);
    in_valid = 1'b0;
    step("seq_accept");

    // Backpressure: hold DONE for 10 cycles with in_valid high.
    out_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step("bp_fill");
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step("bp_hold");
    end
    out_ready = 1'b1;
    step("bp_accept");
    out_ready = 1'b0;
    in_byte   = 8'($urandom);
    step("bp_next");
    check("bp_next_fill", 32'(fill_count), 32'd1);

    // Random input gaps (30% duty) and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(99) < 30);
      in_byte   = 8'($urandom);
      out_ready = 1'($urandom_range(1));
      step("gap");
    end

    // Reset mid-fill after 100 bytes, asserted between edges.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step("drain");
    out_ready = 1'b0;
    for (int i = 0; i < 2 * NB && m_cnt < 100; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step("pre_rst");
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step("post_rst");
    end
    in_valid = 1'b0;
    step("post_rst_accept");

`ifdef BYTES_TO_BITS_SOFT_CLR_EN
    // Soft clear at fill_count=50 with a byte offered in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step("pre_sc");
    end
    soft_clr = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    #1;
    check("sc_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    soft_clr = 1'b0;
    in_valid = 1'b0;
    check_all("soft_clr");
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    step("post_sc");
    in_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
